// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package dmem_arbiter_pkg;

    localparam int WORD_LEN      = 32;
    localparam int DATA_MEM_SIZE = 256;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    typedef logic port_id_t;

    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

    // Request captured at handshake; the byte offset is dropped because
    // DataMem is word-addressed, but the range check used the full address.
    typedef struct packed {
        port_id_t                port;
        logic                    we;
        logic [WORD_LEN-3:0]     word_addr;
        logic [WORD_LEN-1:0]     wdata;
        logic                    err;
    } acc_req_t;

    // A word starting at addr must fit entirely below limit.
    function automatic logic addr_oob(input logic [WORD_LEN-1:0] addr, input int limit);
        return addr >= WORD_LEN'(limit - 3);
    endfunction

endpackage

// File: rtl/dmem_rr_picker.sv
// Picks one of two valid requesters; DMEM_ARB_FIXED_PRIO_EN selects fixed port-0 priority.
// Latency: combinational.
// Backpressure: none; a non-granted port simply stays pending upstream.
module dmem_rr_picker
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  port_id_t   pointer,
    output logic [1:0] grant
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Fixed priority ignores the last-grant history.
    logic unused_pointer;
    assign unused_pointer = pointer;

    // Port 0 wins whenever it is asking.
    always_comb begin
        grant = 2'b00;
        if (valid[0]) begin
            grant = 2'b01;
        end else if (valid[1]) begin
            grant = 2'b10;
        end
    end
`else
    // Ties go to the port that was not granted last; a lone requester always wins.
    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            grant = (pointer == PORT1) ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port load/store arbiter in front of a combinational-read DataMem (DMEM_ARB_FIXED_PRIO_EN: fixed priority).
// Latency: handshake at edge k, memory access in cycle k+1, response pulse in cycle k+2.
// Backpressure: ready only in IDLE for the winning port; losers hold their request until granted.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_LIMIT = DATA_MEM_SIZE
)
(
    input  logic                clk,
    input  logic                rstn,
    input  logic                req0_valid,
    input  logic                req0_we,
    input  logic [WORD_LEN-1:0] req0_addr,
    input  logic [WORD_LEN-1:0] req0_wdata,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic                req1_we,
    input  logic [WORD_LEN-1:0] req1_addr,
    input  logic [WORD_LEN-1:0] req1_wdata,
    output logic                req1_ready,
    output logic                rsp0_valid,
    output logic [WORD_LEN-1:0] rsp0_rdata,
    output logic                rsp0_err,
    output logic                rsp1_valid,
    output logic [WORD_LEN-1:0] rsp1_rdata,
    output logic                rsp1_err,
    output logic                mem_readEn,
    output logic                mem_writeEn,
    output logic [WORD_LEN-1:0] mem_address,
    output logic [WORD_LEN-1:0] mem_datain,
    input  logic [WORD_LEN-1:0] mem_dataout
);

    arb_state_t          state_q, state_d;
    port_id_t            ptr_q;
    logic [1:0]          grant;
    logic                hs;
    acc_req_t            acc_q;
    logic                rsp_vld_q;
    port_id_t            rsp_port_q;
    logic [WORD_LEN-1:0] rsp_rdata_q;
    logic                rsp_err_q;

    dmem_rr_picker u_picker (
        .valid   ({req1_valid, req0_valid}),
        .pointer (ptr_q),
        .grant   (grant)
    );

    // The picker only grants valid ports, so any grant in IDLE is a handshake.
    assign hs = (state_q == IDLE) && (grant != 2'b00);

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, ready handshake and DataMem drive.
    always_comb begin
        state_d     = state_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        mem_readEn  = 1'b0;
        mem_writeEn = 1'b0;
        mem_address = '0;
        mem_datain  = '0;
        case (state_q)
            IDLE: begin
                req0_ready = grant[0];
                req1_ready = grant[1];
                if (hs) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d     = IDLE;
                mem_address = {acc_q.word_addr, 2'b00};
                mem_readEn  = !acc_q.we;
                mem_writeEn = acc_q.we && !acc_q.err;
                mem_datain  = acc_q.wdata;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the winning request and remember who won for the next tie.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q <= '0;
            ptr_q <= PORT1;
        end else if (hs) begin
            if (grant[1]) begin
                acc_q <= '{port: PORT1, we: req1_we, word_addr: req1_addr[WORD_LEN-1:2],
                           wdata: req1_wdata, err: addr_oob(req1_addr, ADDR_LIMIT)};
                ptr_q <= PORT1;
            end else begin
                acc_q <= '{port: PORT0, we: req0_we, word_addr: req0_addr[WORD_LEN-1:2],
                           wdata: req0_wdata, err: addr_oob(req0_addr, ADDR_LIMIT)};
                ptr_q <= PORT0;
            end
        end
    end

    // Response register: loaded at the end of ACCESS, otherwise a single-cycle pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_vld_q   <= 1'b0;
            rsp_port_q  <= PORT0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_vld_q <= (state_q == ACCESS);
            if (state_q == ACCESS) begin
                rsp_port_q  <= acc_q.port;
                rsp_err_q   <= acc_q.err;
                rsp_rdata_q <= (!acc_q.we && !acc_q.err) ? mem_dataout : '0;
            end
        end
    end

    assign rsp0_valid = rsp_vld_q && (rsp_port_q == PORT0);
    assign rsp1_valid = rsp_vld_q && (rsp_port_q == PORT1);
    assign rsp0_rdata = rsp0_valid ? rsp_rdata_q : '0;
    assign rsp1_rdata = rsp1_valid ? rsp_rdata_q : '0;
    assign rsp0_err   = rsp0_valid && rsp_err_q;
    assign rsp1_err   = rsp1_valid && rsp_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural word memory behind it.
// Latency: checks the k+2 response timing on every access.
// Backpressure: holds requests valid across non-ready cycles.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int LIMIT = DATA_MEM_SIZE;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req0_valid, req0_we, req0_ready;
    logic [31:0] req0_addr, req0_wdata;
    logic        req1_valid, req1_we, req1_ready;
    logic [31:0] req1_addr, req1_wdata;
    logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        mem_readEn, mem_writeEn;
    logic [31:0] mem_address, mem_datain, mem_dataout;

    int n_checks = 0;
    int n_fail   = 0;
    int we_cnt   = 0;

    dmem_arbiter #(.ADDR_LIMIT(LIMIT)) dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .mem_readEn(mem_readEn), .mem_writeEn(mem_writeEn),
        .mem_address(mem_address), .mem_datain(mem_datain), .mem_dataout(mem_dataout)
    );

    always #5 clk = ~clk;

    // Word memory: combinational read, write on the clock edge, clearable.
    logic        mem_clr;
    logic [31:0] mem [0:127];
    assign mem_dataout = mem[mem_address[8:2]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 128; i++) mem[i] <= '0;
        end else if (mem_writeEn) begin
            mem[mem_address[8:2]] <= mem_datain;
        end
    end

    always @(negedge clk) begin
        if (mem_writeEn) we_cnt++;
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One request on port p; returns response data/err, latency (negedges after
    // the handshake edge), number of response pulses and the ACCESS-cycle drive.
    task automatic access(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat, output int np,
                          output logic [31:0] acc_addr, output logic acc_we);
        int w;
        @(posedge clk); #1;
        if (p == 0) begin
            req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = d;
        end
        w = 0;
        @(negedge clk);
        while (!(p == 0 ? req0_ready : req1_ready) && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = -1; np = 0; rd = '0; er = 1'b0;
        @(negedge clk);
        acc_addr = mem_address;
        acc_we   = mem_writeEn;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) @(negedge clk);
            if (p == 0 ? rsp0_valid : rsp1_valid) begin
                np++;
                if (lat < 0) begin
                    lat = i;
                    rd  = (p == 0) ? rsp0_rdata : rsp1_rdata;
                    er  = (p == 0) ? rsp0_err : rsp1_err;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] rd, aa;
        logic        er, aw;
        int          lat, np, base, r0, r1, ng, bad;
        int          gr [4];
        int          exp_gr [4];

        rstn = 1'b0; mem_clr = 1'b1;
        req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
        repeat (2) @(posedge clk);
        #1 mem_clr = 1'b0;

        // Reset state
        @(negedge clk);
        check1("rst_ready0", req0_ready, 1'b0);
        check1("rst_ready1", req1_ready, 1'b0);
        check1("rst_rsp0", rsp0_valid, 1'b0);
        check1("rst_rsp1", rsp1_valid, 1'b0);
        check1("rst_rden", mem_readEn, 1'b0);
        check1("rst_wren", mem_writeEn, 1'b0);
        check32("rst_addr", mem_address, 32'h0);
        #2 rstn = 1'b1;

        // Store then load on port 0
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat, np, aa, aw);
        check32("st_lat", 32'(lat), 32'd2);
        check32("st_npulse", 32'(np), 32'd1);
        check32("st_rdata", rd, 32'h0);
        check1("st_err", er, 1'b0);
        check32("st_memaddr", aa, 32'h10);
        check1("st_wren", aw, 1'b1);
        access(0, 1'b0, 32'h10, 32'h0, rd, er, lat, np, aa, aw);
        check32("ld_lat", 32'(lat), 32'd2);
        check32("ld_rdata", rd, 32'hDEADBEEF);
        check1("ld_err", er, 1'b0);

        // Unaligned store on port 1 lands on the containing word
        access(1, 1'b1, 32'h12, 32'h01020304, rd, er, lat, np, aa, aw);
        check32("p1_st_lat", 32'(lat), 32'd2);
        check32("p1_st_memaddr", aa, 32'h10);
        check1("p1_st_err", er, 1'b0);
        access(0, 1'b0, 32'h10, 32'h0, rd, er, lat, np, aa, aw);
        check32("p1_ld_rdata", rd, 32'h01020304);

        // Range boundary
        base = we_cnt;
        access(0, 1'b1, 32'(LIMIT), 32'hCAFEF00D, rd, er, lat, np, aa, aw);
        check1("oob_st_err", er, 1'b1);
        check32("oob_st_rdata", rd, 32'h0);
        check1("oob_st_wren", aw, 1'b0);
        check32("oob_st_wecnt", 32'(we_cnt - base), 32'd0);
        check32("oob_st_mem", mem[64], 32'h0);
        access(0, 1'b1, 32'(LIMIT - 4), 32'hA5A5A5A5, rd, er, lat, np, aa, aw);
        check1("edge_in_err", er, 1'b0);
        base = we_cnt;
        access(0, 1'b1, 32'(LIMIT - 3), 32'h11111111, rd, er, lat, np, aa, aw);
        check1("edge_oob_err", er, 1'b1);
        check32("edge_oob_wecnt", 32'(we_cnt - base), 32'd0);
        access(0, 1'b0, 32'(LIMIT - 4), 32'h0, rd, er, lat, np, aa, aw);
        check32("edge_in_rdata", rd, 32'hA5A5A5A5);
        access(0, 1'b0, 32'(LIMIT), 32'h0, rd, er, lat, np, aa, aw);
        check1("oob_ld_err", er, 1'b1);
        check32("oob_ld_rdata", rd, 32'h0);

        // Back-to-back loads with valid held
        r0 = 0; bad = 0;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h10;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check1($sformatf("b2b_ready_%0d", i), req0_ready, (i % 2) == 0);
            if (rsp0_valid) begin
                r0++;
                if (rsp0_rdata !== 32'h01020304) bad++;
            end
            if (i == 7) begin
                @(posedge clk); #1;
                req0_valid = 1'b0;
            end
        end
        repeat (2) begin
            @(negedge clk);
            if (rsp0_valid) begin
                r0++;
                if (rsp0_rdata !== 32'h01020304) bad++;
            end
        end
        check32("b2b_nrsp", 32'(r0), 32'd4);
        check32("b2b_bad_rdata", 32'(bad), 32'd0);

        // Reset in the middle of a store's ACCESS cycle
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'h20; req0_wdata = 32'h55;
        @(negedge clk);
        check1("abort_ready", req0_ready, 1'b1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        check1("abort_wren_pre", mem_writeEn, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check1("abort_wren_drop", mem_writeEn, 1'b0);
        check32("abort_addr_drop", mem_address, 32'h0);
        @(negedge clk);
        check1("abort_rsp_in_rst", rsp0_valid, 1'b0);
        @(negedge clk);
        #1;
        rstn = 1'b1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h20;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        check1("first_hs_rden", mem_readEn, 1'b1);
        check32("first_hs_addr", mem_address, 32'h20);
        @(negedge clk);
        check1("abort_no_stale_rsp", rsp0_valid, 1'b0);
        @(negedge clk);
        check1("abort_ld_valid", rsp0_valid, 1'b1);
        check32("abort_ld_rdata", rsp0_rdata, 32'h0);

        // Tie-breaking from a fresh reset
        @(negedge clk);
        rstn = 1'b0;
        #2 rstn = 1'b1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        exp_gr = '{0, 0, 0, 0};
`else
        exp_gr = '{0, 1, 0, 1};
`endif
        gr = '{-1, -1, -1, -1};
        ng = 0; r0 = 0; r1 = 0;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h10;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h10;
        for (int i = 0; i < 20 && ng < 4; i++) begin
            @(negedge clk);
            if (rsp0_valid) r0++;
            if (rsp1_valid) r1++;
            if (req0_ready) begin
                gr[ng] = 0; ng++;
            end else if (req1_ready) begin
                gr[ng] = 1; ng++;
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp0_valid) r0++;
            if (rsp1_valid) r1++;
        end
        check32("tie_ngrants", 32'(ng), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check32($sformatf("tie_grant_%0d", i), 32'(gr[i]), 32'(exp_gr[i]));
        end
`ifdef DMEM_ARB_FIXED_PRIO_EN
        check32("tie_nrsp0", 32'(r0), 32'd4);
        check32("tie_nrsp1", 32'(r1), 32'd0);
`else
        check32("tie_nrsp0", 32'(r0), 32'd2);
        check32("tie_nrsp1", 32'(r1), 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
